// File: rtl/ps_mem_pkg.sv
// Shared definitions for the ps_mem slave.
//   ps_state_e   - read-path FSM states
//   RESP_OKAY    - write response for an in-range write
//   RESP_SLVERR  - write response for an out-of-range (dropped) write
package ps_mem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdMem  = 2'd1,
        StRdResp = 2'd2
    } ps_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ps_if.sv
// Simple write/read bus between one master and one memory slave.
//   waddr/wdata/wvalid -> wready, wresp : write channel, response registered
//   raddr/arvalid      -> rdata/rvalid, rready : read channel, arvalid is a
//                         single-cycle request with no back-pressure
interface ps_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            wresp;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  arvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  waddr, wdata, wvalid, raddr, arvalid, rready,
        output wready, wresp, rdata, rvalid
    );

    modport master (
        output waddr, wdata, wvalid, raddr, arvalid, rready,
        input  wready, wresp, rdata, rvalid
    );
endinterface

// File: rtl/ps_mem_ram.sv
// Single-port synchronous RAM, no reset.
//   clk_i   : clock
//   we_i    : write enable (takes priority over re_i)
//   re_i    : read enable, rdata_o valid the cycle after
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data, holds until the next read
module ps_mem_ram #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic                   re_i,
    input  logic [INDEX_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]  wdata_i,
    output logic [DATA_WIDTH-1:0]  rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ps_mem_slave.sv
// Word-addressed memory slave on a ps_if bus.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset (storage is not cleared)
//   ps_s_i      : ps_if slave modport (widths taken from the interface)
//   rd_overflow : sticky, set when an arvalid pulse had to be dropped
// Reads go IDLE -> RD_MEM -> RD_RESP. A read that cannot be issued at once is
// parked in a 1-entry pending register; a pending read is issued before any
// new write is accepted so bus order is preserved.
module ps_mem_slave
    import ps_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic clk,
    input  logic rst_n,
    ps_if.slave  ps_s_i,
    output logic rd_overflow
);
    localparam int unsigned DW = $bits(ps_s_i.wdata);
    localparam int unsigned AW = $bits(ps_s_i.waddr);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DepthLim = (AW + 1)'(DEPTH);

    if (64'(DEPTH) > (64'd1 << AW)) begin : g_depth_err
        $error("ps_mem_slave: DEPTH exceeds the address space of ps_if");
    end

    ps_state_e       state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      wresp_q, wresp_d;
    logic            ovf_q, ovf_d;
    logic            rd_ok_q, rd_ok_d;

    logic            wready;
    logic            wr_fire;
    logic            wr_in_range;
    logic            rd_issue;
    logic            rd_direct;
    logic            rd_in_range;
    logic [AW-1:0]   rd_addr;
    logic            ram_we;
    logic            ram_re;
    logic [IW-1:0]   ram_addr;
    logic [DW-1:0]   ram_rdata;

    // Gated by rst_n so wready reads low while reset is held.
    assign wready      = rst_n && (state_q == StIdle) && !pend_valid_q;
    assign wr_fire     = ps_s_i.wvalid && wready;
    assign wr_in_range = ({1'b0, ps_s_i.waddr} < DepthLim);

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        rd_ok_d      = rd_ok_q;
        ovf_d        = ovf_q;
        wresp_d      = wresp_q;
        rd_issue     = 1'b0;
        rd_direct    = 1'b0;
        rd_addr      = ps_s_i.raddr;

        unique case (state_q)
            StIdle: begin
                if (pend_valid_q) begin
                    rd_issue     = 1'b1;
                    rd_addr      = pend_addr_q;
                    pend_valid_d = 1'b0;
                end else if (ps_s_i.arvalid && !wr_fire) begin
                    rd_issue  = 1'b1;
                    rd_direct = 1'b1;
                end
            end
            StRdMem: begin
                state_d  = StRdResp;
                rvalid_d = 1'b1;
                rdata_d  = rd_ok_q ? ram_rdata : '0;
            end
            StRdResp: begin
                if (ps_s_i.rready) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        rd_in_range = ({1'b0, rd_addr} < DepthLim);
        if (rd_issue) begin
            state_d = StRdMem;
            rd_ok_d = rd_in_range;
        end

        // Every arvalid not issued directly goes to pending; if pending is
        // occupied (even if it is being issued this cycle) the request is lost.
        if (ps_s_i.arvalid && !rd_direct) begin
            if (pend_valid_q) begin
                ovf_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_addr_d  = ps_s_i.raddr;
            end
        end

        if (wr_fire) begin
            wresp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Writes and read issues are mutually exclusive by construction.
    assign ram_we   = wr_fire && wr_in_range;
    assign ram_re   = rd_issue && rd_in_range;
    assign ram_addr = ram_we ? ps_s_i.waddr[IW-1:0] : rd_addr[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            wresp_q      <= RESP_OKAY;
            ovf_q        <= 1'b0;
            rd_ok_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            wresp_q      <= wresp_d;
            ovf_q        <= ovf_d;
            rd_ok_q      <= rd_ok_d;
        end
    end

    ps_mem_ram #(
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (DW),
        .INDEX_WIDTH (IW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ps_s_i.wdata),
        .rdata_o (ram_rdata)
    );

    assign ps_s_i.wready = wready;
    assign ps_s_i.wresp  = wresp_q;
    assign ps_s_i.rvalid = rvalid_q;
    assign ps_s_i.rdata  = rdata_q;
    assign rd_overflow   = ovf_q;
endmodule

// File: tb/tb_ps_mem_slave.sv
// Bench for ps_mem_slave: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_ps_mem_slave;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rd_overflow;

    ps_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

    ps_mem_slave #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps_s_i      (bus),
        .rd_overflow (rd_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- model: memory + read request queue ----------------
    logic [31:0] m_mem [DEPTH];
    int unsigned m_pend [$];   // reads accepted but not yet started (at most one)
    bit          m_busy  = 1'b0;
    int          m_age   = 0;  // cycles since the outstanding read was started
    logic [31:0] m_data  = '0;
    logic [1:0]  m_wresp = 2'b00;
    bit          m_ovf   = 1'b0;

    function automatic bit exp_wready();
        return (rst_n === 1'b1) && !m_busy && (m_pend.size() == 0);
    endfunction

    function automatic bit exp_rvalid();
        return m_busy && (m_age >= 1);
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_busy  = 1'b0;
        m_age   = 0;
        m_data  = '0;
        m_wresp = 2'b00;
        m_ovf   = 1'b0;
    endtask

    task automatic start_read(input int unsigned a);
        m_busy = 1'b1;
        m_age  = 0;
        m_data = (a < DEPTH) ? m_mem[a] : 32'h0;
    endtask

    // Advance the model across one rising edge given that cycle's inputs.
    task automatic model_step(input bit wv, input int unsigned wa, input logic [31:0] wd,
                              input bit av, input int unsigned ra, input bit rr);
        bit wfire;
        bit full;
        bit direct;
        if (rst_n !== 1'b1) begin
            model_reset();
            return;
        end
        wfire  = wv && exp_wready();
        full   = (m_pend.size() != 0);
        direct = 1'b0;
        if (m_busy) begin
            if (m_age >= 1 && rr) m_busy = 1'b0;
            else m_age = 1;
        end else if (full) begin
            start_read(m_pend.pop_front());
        end else if (av && !wfire) begin
            start_read(ra);
            direct = 1'b1;
        end
        if (av && !direct) begin
            if (full) m_ovf = 1'b1;
            else m_pend.push_back(ra);
        end
        if (wfire) begin
            if (wa < DEPTH) m_mem[wa] = wd;
            m_wresp = (wa < DEPTH) ? 2'b00 : 2'b10;
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("wready", bus.wready, exp_wready());
            check("rvalid", bus.rvalid, exp_rvalid());
            if (exp_rvalid()) check("rdata", bus.rdata, m_data);
            if (rst_n !== 1'b1) check("rdata_in_reset", bus.rdata, 0);
            check("wresp", bus.wresp, m_wresp);
            check("rd_overflow", rd_overflow, m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit wv, input int unsigned wa, input logic [31:0] wd,
                        input bit av, input int unsigned ra, input bit rr);
        bus.wvalid  = wv;
        bus.waddr   = wa[AW-1:0];
        bus.wdata   = wd;
        bus.arvalid = av;
        bus.raddr   = ra[AW-1:0];
        bus.rready  = rr;
        @(posedge clk);
        model_step(wv, wa, wd, av, ra, rr);
        #1;
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 0, 32'h0, 1'b0, 0, rr);
    endtask

    task automatic wait_rvalid(input string name);
        int n = 0;
        while (bus.rvalid !== 1'b1 && n < 10) begin
            idle(1'b0);
            n++;
        end
        check({name, "_rvalid_arrives"}, bus.rvalid, 1);
    endtask

    initial begin
        bus.wvalid  = 1'b0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.arvalid = 1'b0;
        bus.raddr   = '0;
        bus.rready  = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wready", bus.wready, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_wresp", bus.wresp, 0);
        check("rst_ovf", rd_overflow, 0);
        rst_n = 1'b1;
        #1;
        check("wready_after_release", bus.wready, 1);

        for (int a = 0; a < int'(DEPTH); a++) step(1'b1, a, 32'h1000_0000 + a, 1'b0, 0, 1'b0);

        // Out-of-range write is dropped with SLVERR and does not alias.
        step(1'b1, 256, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        check("oor_write_wresp", bus.wresp, 2'b10);
        step(1'b0, 0, 32'h0, 1'b1, 256, 1'b0);
        wait_rvalid("oor_read");
        check("oor_read_rdata", bus.rdata, 0);
        idle(1'b1);
        step(1'b0, 0, 32'h0, 1'b1, 0, 1'b0);
        wait_rvalid("addr0_read");
        check("addr0_unchanged", bus.rdata, 32'h1000_0000);
        idle(1'b1);

        // Basic write then read with exact latency.
        step(1'b1, 3, 32'hA5A5_0001, 1'b0, 0, 1'b0);
        check("w3_wresp", bus.wresp, 2'b00);
        step(1'b0, 0, 32'h0, 1'b1, 3, 1'b0);
        check("r3_rvalid_n1", bus.rvalid, 0);
        idle(1'b0);
        check("r3_rvalid_n2", bus.rvalid, 1);
        check("r3_rdata", bus.rdata, 32'hA5A5_0001);
        idle(1'b1);
        check("r3_rvalid_dropped", bus.rvalid, 0);

        // Same-cycle write and read: read returns the new data.
        step(1'b1, 7, 32'h0000_1234, 1'b1, 7, 1'b0);
        check("raw_wready_low", bus.wready, 0);
        wait_rvalid("raw");
        check("raw_rdata", bus.rdata, 32'h0000_1234);
        idle(1'b1);

        // Last word is in range.
        step(1'b1, 255, 32'h0000_00FF, 1'b0, 0, 1'b0);
        check("w255_wresp", bus.wresp, 2'b00);
        step(1'b0, 0, 32'h0, 1'b1, 255, 1'b0);
        wait_rvalid("r255");
        check("r255_rdata", bus.rdata, 32'h0000_00FF);
        idle(1'b1);

        // Stall in RD_RESP with a second read parked in pending.
        step(1'b0, 0, 32'h0, 1'b1, 10, 1'b0);
        wait_rvalid("stall");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 0, 32'h0, (i == 2), 11, 1'b0);
            check("stall_rvalid", bus.rvalid, 1);
            check("stall_rdata", bus.rdata, 32'h1000_000A);
            check("stall_wready", bus.wready, 0);
        end
        idle(1'b1);
        check("stall_rvalid_low", bus.rvalid, 0);
        wait_rvalid("stall_pend");
        check("stall_pend_rdata", bus.rdata, 32'h1000_000B);
        idle(1'b1);

        // Read 20 in flight, then 21 (pending) and 22 (lost) during RD_RESP.
        step(1'b0, 0, 32'h0, 1'b1, 20, 1'b0);
        idle(1'b0);
        check("ovf_first_rvalid", bus.rvalid, 1);
        check("ovf_first_rdata", bus.rdata, 32'h1000_0014);
        step(1'b0, 0, 32'h0, 1'b1, 21, 1'b0);
        check("ovf_not_yet", rd_overflow, 0);
        step(1'b0, 0, 32'h0, 1'b1, 22, 1'b0);
        check("ovf_set", rd_overflow, 1);
        idle(1'b1);
        wait_rvalid("ovf_second");
        check("ovf_second_rdata", bus.rdata, 32'h1000_0015);
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("ovf_third_lost", bus.rvalid, 0);
        end
        check("ovf_sticky", rd_overflow, 1);

        // Reset during RD_MEM aborts the read; storage survives.
        step(1'b0, 0, 32'h0, 1'b1, 3, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_rvalid", bus.rvalid, 0);
        idle(1'b1);
        idle(1'b1);
        check("abort_rvalid_held", bus.rvalid, 0);
        rst_n = 1'b1;
        #1;
        check("abort_wready", bus.wready, 1);
        check("abort_ovf_cleared", rd_overflow, 0);
        step(1'b0, 0, 32'h0, 1'b1, 3, 1'b0);
        wait_rvalid("abort_reread");
        check("abort_reread_rdata", bus.rdata, 32'hA5A5_0001);
        idle(1'b1);

        // Randomized traffic, including out-of-range addresses and a reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (i == 1503) rst_n = 1'b1;
            step(($urandom_range(0, 99) < 40), $urandom_range(0, 299), $urandom,
                 ($urandom_range(0, 99) < 25), $urandom_range(0, 299),
                 ($urandom_range(0, 99) < 60));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
